vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen_if.sv | 32 +++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if -- raster timing bundle produced by vga_timing_gen.
//   pix_en      : one-clock pixel strobe
//   h_count     : current pixel column
//   v_count     : current line
//   display_en  : current pixel lies in the visible area
//   h_sync      : horizontal sync (polarity set by the generator)
//   v_sync      : vertical sync (polarity set by the generator)
//   line_start  : one-clock pulse after h_count returns to 0
//   frame_start : one-clock pulse after (h_count, v_count) returns to (0, 0)
//   frame_count : completed frames, wrapping at 256
// master = timing generator, slave = pixel pipeline consuming the timing.
interface vga_timing_gen_if;
  logic       pix_en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       display_en;
  logic       h_sync;
  logic       v_sync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pix_en, h_count, v_count, display_en, h_sync, v_sync,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  pix_en, h_count, v_count, display_en, h_sync, v_sync,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
// Divides clk_in down to a pixel strobe and walks an H_TOTAL x V_TOTAL raster,
// producing counters, blanking, sync and start-of-line/frame markers.
// Ports:
//   clk_in : system clock, all logic on the rising edge
//   reset  : synchronous, active-high reset
//   vga    : timing bundle (master side), see vga_timing_gen_if
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_nxt;
  logic       pix_en_q;
  logic [9:0] h_q, v_q, h_nxt, v_nxt;
  logic       h_wrap, v_wrap;
  logic       de_q, hs_q, vs_q, ls_q, fs_q;
  logic       hs_act, vs_act;
  logic       started_q;
  logic [7:0] fc_q;

  always @(posedge clk_in) begin
    assert (H_TOTAL <= 1024 && V_TOTAL <= 1024 && CLK_DIV >= 1 && CLK_DIV <= 16)
      else $fatal(1, "vga_timing_gen: illegal timing parameters");
  end

  always_comb begin
    div_nxt = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    h_wrap  = (h_q == H_LAST);
    v_wrap  = (v_q == V_LAST);
    h_nxt   = h_wrap ? 10'd0 : h_q + 10'd1;
    v_nxt   = v_q;
    if (h_wrap) begin
      v_nxt = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    hs_act  = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
    vs_act  = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
  end

  // Decoded outputs are computed from the next-state counters so they land
  // in the same cycle as the counter values they describe.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_q     <= 4'd0;
      pix_en_q  <= 1'b0;
      h_q       <= H_LAST;
      v_q       <= V_LAST;
      de_q      <= 1'b0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      started_q <= 1'b0;
      fc_q      <= 8'd0;
    end else begin
      div_q    <= div_nxt;
      pix_en_q <= (div_nxt == DIV_LAST);
      if (pix_en_q) begin
        h_q       <= h_nxt;
        v_q       <= v_nxt;
        de_q      <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_q      <= hs_act ? HS_POL : ~HS_POL;
        vs_q      <= vs_act ? VS_POL : ~VS_POL;
        ls_q      <= (h_nxt == 10'd0);
        fs_q      <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
        started_q <= 1'b1;
        // The wrap out of the reset position opens frame 0; only later
        // wraps close a frame and count it.
        if (started_q && h_wrap && v_wrap) begin
          fc_q <= fc_q + 8'd1;
        end
      end else begin
        // Markers are single clk_in pulses even when a pixel spans several clocks.
        ls_q <= 1'b0;
        fs_q <= 1'b0;
      end
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.h_count     = h_q;
  assign vga.v_count     = v_q;
  assign vga.display_en  = de_q;
  assign vga.h_sync      = hs_q;
  assign vga.v_sync      = vs_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- three generator instances (defaults, a small raster with
// CLK_DIV=3 and random mid-frame resets, a tiny positive-sync raster with
// CLK_DIV=1 run to frame_count wrap) checked every cycle against a counting model.
module tb_vga_timing_gen;
  localparam int NDUT = 3;
  localparam int P_HA  [NDUT] = '{640, 10, 8};
  localparam int P_HF  [NDUT] = '{16, 2, 2};
  localparam int P_HS  [NDUT] = '{96, 3, 3};
  localparam int P_HB  [NDUT] = '{48, 5, 3};
  localparam int P_VA  [NDUT] = '{480, 6, 4};
  localparam int P_VF  [NDUT] = '{10, 2, 1};
  localparam int P_VS  [NDUT] = '{2, 2, 2};
  localparam int P_VB  [NDUT] = '{33, 3, 1};
  localparam int P_DIV [NDUT] = '{2, 3, 1};
  localparam bit P_HP  [NDUT] = '{1'b0, 1'b0, 1'b1};
  localparam bit P_VP  [NDUT] = '{1'b0, 1'b0, 1'b1};

  logic            clk_in = 1'b0;
  logic [NDUT-1:0] rst = '1;
  logic [NDUT-1:0] rst_cap;
  logic            seen_edge = 1'b0;
  int              n_tests = 0;
  int              n_fail = 0;

  always #5 clk_in = ~clk_in;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif2 ();

  vga_timing_gen u_dut0 (.clk_in(clk_in), .reset(rst[0]), .vga(vif0));

  vga_timing_gen #(
    .H_ACTIVE(P_HA[1]), .H_FP(P_HF[1]), .H_SYNC(P_HS[1]), .H_BP(P_HB[1]),
    .V_ACTIVE(P_VA[1]), .V_FP(P_VF[1]), .V_SYNC(P_VS[1]), .V_BP(P_VB[1]),
    .HS_POL(P_HP[1]), .VS_POL(P_VP[1]), .CLK_DIV(P_DIV[1])
  ) u_dut1 (.clk_in(clk_in), .reset(rst[1]), .vga(vif1));

  vga_timing_gen #(
    .H_ACTIVE(P_HA[2]), .H_FP(P_HF[2]), .H_SYNC(P_HS[2]), .H_BP(P_HB[2]),
    .V_ACTIVE(P_VA[2]), .V_FP(P_VF[2]), .V_SYNC(P_VS[2]), .V_BP(P_VB[2]),
    .HS_POL(P_HP[2]), .VS_POL(P_VP[2]), .CLK_DIV(P_DIV[2])
  ) u_dut2 (.clk_in(clk_in), .reset(rst[2]), .vga(vif2));

  logic       act_pe [NDUT];
  logic [9:0] act_h  [NDUT];
  logic [9:0] act_v  [NDUT];
  logic       act_de [NDUT];
  logic       act_hs [NDUT];
  logic       act_vs [NDUT];
  logic       act_ls [NDUT];
  logic       act_fs [NDUT];
  logic [7:0] act_fc [NDUT];

  assign act_pe[0] = vif0.pix_en;      assign act_pe[1] = vif1.pix_en;      assign act_pe[2] = vif2.pix_en;
  assign act_h[0]  = vif0.h_count;     assign act_h[1]  = vif1.h_count;     assign act_h[2]  = vif2.h_count;
  assign act_v[0]  = vif0.v_count;     assign act_v[1]  = vif1.v_count;     assign act_v[2]  = vif2.v_count;
  assign act_de[0] = vif0.display_en;  assign act_de[1] = vif1.display_en;  assign act_de[2] = vif2.display_en;
  assign act_hs[0] = vif0.h_sync;      assign act_hs[1] = vif1.h_sync;      assign act_hs[2] = vif2.h_sync;
  assign act_vs[0] = vif0.v_sync;      assign act_vs[1] = vif1.v_sync;      assign act_vs[2] = vif2.v_sync;
  assign act_ls[0] = vif0.line_start;  assign act_ls[1] = vif1.line_start;  assign act_ls[2] = vif2.line_start;
  assign act_fs[0] = vif0.frame_start; assign act_fs[1] = vif1.frame_start; assign act_fs[2] = vif2.frame_start;
  assign act_fc[0] = vif0.frame_count; assign act_fc[1] = vif1.frame_count; assign act_fc[2] = vif2.frame_count;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) begin
    rst_cap   <= rst;
    seen_edge <= 1'b1;
  end

  // Reference model: j = clocks since reset release, u = pixel updates since
  // release. Raster position is plain arithmetic on u.
  int m_j [NDUT];
  int m_u [NDUT];
  bit m_pe [NDUT];

  always @(negedge clk_in) begin
    int ht, vt, n, idx, h, v, fc;
    bit upd, de, hs, vs, ls, fs;
    string p;
    if (seen_edge) begin
      for (int k = 0; k < NDUT; k++) begin
        if (rst_cap[k]) begin
          m_j[k] = 0;
          m_u[k] = 0;
          upd    = 1'b0;
        end else begin
          upd = m_pe[k];
          if (upd) m_u[k]++;
          m_j[k]++;
        end
        m_pe[k] = (m_j[k] > 0) && ((m_j[k] % P_DIV[k]) == P_DIV[k] - 1);
        ht = P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
        vt = P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k];
        n  = ht * vt;
        if (m_u[k] == 0) begin
          h = ht - 1; v = vt - 1; fc = 0;
        end else begin
          idx = (m_u[k] - 1) % n;
          h   = idx % ht;
          v   = idx / ht;
          fc  = ((m_u[k] - 1) / n) % 256;
        end
        de = (h < P_HA[k]) && (v < P_VA[k]);
        hs = ((h >= P_HA[k] + P_HF[k]) && (h < P_HA[k] + P_HF[k] + P_HS[k])) ? P_HP[k] : !P_HP[k];
        vs = ((v >= P_VA[k] + P_VF[k]) && (v < P_VA[k] + P_VF[k] + P_VS[k])) ? P_VP[k] : !P_VP[k];
        ls = upd && (h == 0);
        fs = ls && (v == 0);
        p  = $sformatf("d%0d_", k);
        chk({p, "pix_en"},      32'(act_pe[k]), 32'(m_pe[k]));
        chk({p, "h_count"},     32'(act_h[k]),  h);
        chk({p, "v_count"},     32'(act_v[k]),  v);
        chk({p, "display_en"},  32'(act_de[k]), 32'(de));
        chk({p, "h_sync"},      32'(act_hs[k]), 32'(hs));
        chk({p, "v_sync"},      32'(act_vs[k]), 32'(vs));
        chk({p, "line_start"},  32'(act_ls[k]), 32'(ls));
        chk({p, "frame_start"}, 32'(act_fs[k]), 32'(fs));
        chk({p, "frame_count"}, 32'(act_fc[k]), fc);
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk_in);
    chk("rst_h",  32'(act_h[0]), 799);
    chk("rst_v",  32'(act_v[0]), 524);
    chk("rst_pe", 32'(act_pe[0]), 0);
    chk("rst_de", 32'(act_de[0]), 0);
    chk("rst_hs", 32'(act_hs[0]), 1);
    chk("rst_vs", 32'(act_vs[0]), 1);
    chk("rst_ls", 32'(act_ls[0]), 0);
    chk("rst_fs", 32'(act_fs[0]), 0);
    chk("rst_fc", 32'(act_fc[0]), 0);
    rst = '0;
    @(negedge clk_in);
    chk("rel_pe_first", 32'(act_pe[0]), 1);
    chk("rel_h_held",   32'(act_h[0]), 799);
    @(negedge clk_in);
    chk("start_h",  32'(act_h[0]), 0);
    chk("start_v",  32'(act_v[0]), 0);
    chk("start_de", 32'(act_de[0]), 1);
    chk("start_ls", 32'(act_ls[0]), 1);
    chk("start_fs", 32'(act_fs[0]), 1);
    chk("start_fc", 32'(act_fc[0]), 0);
    chk("start_pe", 32'(act_pe[0]), 0);
    @(negedge clk_in);
    chk("after_ls", 32'(act_ls[0]), 0);
    chk("after_fs", 32'(act_fs[0]), 0);
    chk("after_pe", 32'(act_pe[0]), 1);

    fork
      begin : br_defaults
        int pe_cnt, lines;
        pe_cnt = 1;  // strobe seen in the cycle just checked
        lines  = 0;
        for (int c = 0; c < 4000 && lines < 2; c++) begin
          @(negedge clk_in);
          if (act_ls[0]) begin
            chk("d0_pix_per_line", pe_cnt, 800);
            pe_cnt = 0;
            lines++;
          end else if (act_pe[0]) begin
            pe_cnt++;
          end
          if (act_h[0] == 10'd655) chk("d0_hs_655", 32'(act_hs[0]), 1);
          if (act_h[0] == 10'd656) chk("d0_hs_656", 32'(act_hs[0]), 0);
          if (act_h[0] == 10'd751) chk("d0_hs_751", 32'(act_hs[0]), 0);
          if (act_h[0] == 10'd752) chk("d0_hs_752", 32'(act_hs[0]), 1);
          if (act_h[0] == 10'd639) chk("d0_de_639", 32'(act_de[0]), 1);
          if (act_h[0] == 10'd640) chk("d0_de_640", 32'(act_de[0]), 0);
        end
        if (lines < 2) chk("d0_line_timeout", 0, 1);
      end

      begin : br_small
        bit hit;
        int per, nls;
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
          @(negedge clk_in);
          if (act_h[1] == 10'd7 && act_v[1] == 10'd3 && !act_pe[1]) hit = 1'b1;
        end
        chk("d1_reach_7_3", 32'(hit), 1);
        rst[1] = 1'b1;
        @(negedge clk_in);
        chk("d1_mid_rst_h",  32'(act_h[1]), 19);
        chk("d1_mid_rst_v",  32'(act_v[1]), 12);
        chk("d1_mid_rst_hs", 32'(act_hs[1]), 1);
        chk("d1_mid_rst_vs", 32'(act_vs[1]), 1);
        chk("d1_mid_rst_fc", 32'(act_fc[1]), 0);
        chk("d1_mid_rst_ls", 32'(act_ls[1]), 0);
        rst[1] = 1'b0;
        @(negedge clk_in);
        chk("d1_rel_pe1", 32'(act_pe[1]), 0);
        @(negedge clk_in);
        chk("d1_rel_pe2", 32'(act_pe[1]), 1);
        @(negedge clk_in);
        chk("d1_restart_h",  32'(act_h[1]), 0);
        chk("d1_restart_v",  32'(act_v[1]), 0);
        chk("d1_restart_fs", 32'(act_fs[1]), 1);
        chk("d1_restart_fc", 32'(act_fc[1]), 0);
        per = 0; nls = 0; hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
          @(negedge clk_in);
          per++;
          if (act_ls[1]) nls++;
          if (act_fs[1]) hit = 1'b1;
        end
        chk("d1_frame_period", per, 780);
        chk("d1_lines_per_frame", nls, 13);
        chk("d1_fc_one", 32'(act_fc[1]), 1);
        for (int r = 0; r < 5; r++) begin
          repeat ($urandom_range(40, 900)) @(negedge clk_in);
          for (int c = 0; c < 4 && act_pe[1]; c++) @(negedge clk_in);
          rst[1] = 1'b1;
          repeat ($urandom_range(1, 4)) @(negedge clk_in);
          chk("d1_rnd_rst_h",  32'(act_h[1]), 19);
          chk("d1_rnd_rst_v",  32'(act_v[1]), 12);
          chk("d1_rnd_rst_fc", 32'(act_fc[1]), 0);
          chk("d1_rnd_rst_fs", 32'(act_fs[1]), 0);
          rst[1] = 1'b0;
        end
        repeat (1700) @(negedge clk_in);
      end

      begin : br_wrap
        int nfs;
        bit wrapped;
        logic [7:0] last_fc;
        nfs = 0; wrapped = 1'b0; last_fc = 8'd0;
        for (int c = 0; c < 40000 && !wrapped; c++) begin
          @(negedge clk_in);
          if (act_fs[2]) begin
            nfs++;
            if (act_fc[2] == 8'd0) begin
              wrapped = 1'b1;
              chk("d2_fc_before_wrap", 32'(last_fc), 255);
              chk("d2_frames_to_wrap", nfs, 256);
              chk("d2_wrap_h", 32'(act_h[2]), 0);
              chk("d2_wrap_v", 32'(act_v[2]), 0);
            end
            last_fc = act_fc[2];
          end
          if (act_v[2] == 10'd0) begin
            if (act_h[2] == 10'd9)  chk("d2_hs_9",  32'(act_hs[2]), 0);
            if (act_h[2] == 10'd10) chk("d2_hs_10", 32'(act_hs[2]), 1);
            if (act_h[2] == 10'd12) chk("d2_hs_12", 32'(act_hs[2]), 1);
            if (act_h[2] == 10'd13) chk("d2_hs_13", 32'(act_hs[2]), 0);
          end
        end
        chk("d2_wrap_seen", 32'(wrapped), 1);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
